// File: rtl/axi_read_xfer_sched.sv
// Purpose : splits one read command into bursts (max C_MAX_BURST_BYTES, never crossing 4 KB)
//           and sequences the burst reader; flags the final beat and reports done/err.
// Latency : first burst_run 2 cycles after command accept; next burst_run 2 cycles after a
//           burst's last handshake; done 2 cycles after the final handshake.
// Backpr. : cmd_ready only in IDLE (no queueing); the mon_* stream is observed, never stalled.
//
// Ports:
//   m_axi_aclk, m_axi_areset             clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_addr/cmd_len  transfer command (byte address, byte count)
//   burst_run/burst_addr/burst_byte_length  per-burst request to the reader (run is a pulse)
//   mon_tvalid/mon_tready/mon_tlast      monitored reader output stream
//   xfer_tlast                           mon_tlast qualified to the final burst of the transfer
//   busy/done/err                        status; err is meaningful only while done=1
module axi_read_xfer_sched #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_MAX_BURST_BYTES  = 512,
  parameter int C_LEN_WIDTH        = 24
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_LEN_WIDTH-1:0]        cmd_len,
  output logic                          burst_run,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] burst_addr,
  output logic [9:0]                    burst_byte_length,
  input  logic                          mon_tvalid,
  input  logic                          mon_tready,
  input  logic                          mon_tlast,
  output logic                          xfer_tlast,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int BPB      = C_M_AXI_DATA_WIDTH / 8;
  localparam int BPB_LOG2 = $clog2(BPB);
  // Size arithmetic must hold both the remaining length and the 4 KB room (up to 4096).
  localparam int CW       = (C_LEN_WIDTH > 13) ? C_LEN_WIDTH : 13;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [C_M_AXI_ADDR_WIDTH-1:0] r_cur_addr;
  logic [C_LEN_WIDTH-1:0]        r_rem;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_burst_addr;
  logic [9:0]                    r_burst_len;
  logic [9:0]                    r_beat_cnt;
  logic                          r_last_burst;
  logic                          r_err;

  logic          w_cmd_fire;
  logic          w_misaligned;
  logic          w_rem_zero;
  logic          w_beat;
  logic          w_last_hs;
  logic [CW-1:0] w_lo12;
  logic [CW-1:0] w_rem_ext;
  logic [CW-1:0] w_room_max;
  logic [CW-1:0] w_room_4k;
  logic [CW-1:0] w_size;
  logic [9:0]    w_beats_exp;
  logic [9:0]    w_cnt_inc;
  logic          w_unused_size;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  assign w_cmd_fire   = cmd_valid & cmd_ready;
  assign w_misaligned = (|(cmd_addr & C_M_AXI_ADDR_WIDTH'(BPB - 1))) |
                        (|(cmd_len  & C_LEN_WIDTH'(BPB - 1)));
  assign w_rem_zero   = (r_rem == '0);

  assign w_beat    = mon_tvalid & mon_tready;
  assign w_last_hs = w_beat & mon_tlast;

  // Burst size = min(remaining, room to the next max-burst boundary, room to the next 4 KB
  // page). C_MAX_BURST_BYTES divides 4096, so the low 12 address bits carry both offsets.
  assign w_lo12     = CW'(r_cur_addr[11:0]);
  assign w_rem_ext  = CW'(r_rem);
  assign w_room_max = CW'(C_MAX_BURST_BYTES) - (w_lo12 & CW'(C_MAX_BURST_BYTES - 1));
  assign w_room_4k  = CW'(4096) - w_lo12;

  always_comb begin
    w_size = w_rem_ext;
    if (w_room_max < w_size) w_size = w_room_max;
    if (w_room_4k  < w_size) w_size = w_room_4k;
  end

  // The result never exceeds C_MAX_BURST_BYTES (<= 512), so only the low 10 bits matter.
  assign w_unused_size = ^w_size[CW-1:10];

  assign w_beats_exp = r_burst_len >> BPB_LOG2;
  assign w_cnt_inc   = r_beat_cnt + 10'd1;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // A misaligned command never issues a burst; it goes straight to completion.
        if (w_cmd_fire) w_state_nxt = w_misaligned ? S_FIN : S_CALC;
      end
      S_CALC: begin
        w_state_nxt = w_rem_zero ? S_FIN : S_ISSUE;
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Only the reader's tlast ends a burst; a short or long burst is still followed
        // through so the reader is back in IDLE before the next run pulse.
        if (w_last_hs) w_state_nxt = S_CALC;
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    burst_run = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_ISSUE: begin
        burst_run = 1'b1;
      end
      S_FIN: begin
        done = 1'b1;
        err  = r_err;
      end
      default: begin
      end
    endcase
  end

  assign xfer_tlast        = mon_tlast & r_last_burst & (r_state == S_WAIT);
  assign burst_addr        = r_burst_addr;
  assign burst_byte_length = r_burst_len;

  // ---------------------------------------------------------------------------
  // Datapath: address/length bookkeeping, beat counting, sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      r_cur_addr   <= '0;
      r_rem        <= '0;
      r_burst_addr <= '0;
      r_burst_len  <= '0;
      r_beat_cnt   <= '0;
      r_last_burst <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_cur_addr <= cmd_addr;
            r_rem      <= cmd_len;
            if (w_misaligned) r_err <= 1'b1;
          end
        end
        S_CALC: begin
          // burst_addr/burst_byte_length are only written here, so they stay stable
          // through ISSUE and WAIT while the reader latches them on run.
          if (!w_rem_zero) begin
            r_burst_addr <= r_cur_addr;
            r_burst_len  <= w_size[9:0];
            r_beat_cnt   <= '0;
          end
        end
        S_ISSUE: begin
          // Address wraps naturally; the 4 KB split keeps bursts off the wrap point.
          r_cur_addr   <= r_cur_addr + C_M_AXI_ADDR_WIDTH'(r_burst_len);
          r_rem        <= r_rem - C_LEN_WIDTH'(r_burst_len);
          r_last_burst <= (r_rem == C_LEN_WIDTH'(r_burst_len));
        end
        S_WAIT: begin
          if (w_beat) begin
            r_beat_cnt <= w_cnt_inc;
            // Error when tlast arrives early/late, or the expected count is reached
            // without tlast (the FSM then keeps waiting for tlast).
            if ((w_cnt_inc == w_beats_exp) ^ mon_tlast) r_err <= 1'b1;
          end
        end
        S_FIN: begin
          r_err <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
